// File: rtl/instr_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_dispatch_if
// Description : Bundles the instruction handshake, the decoded-field bus, the
//               per-unit start/done pairs and the status outputs of the
//               instruction dispatcher.
//               master : the dispatcher (drives ready, fields, starts, status)
//               slave  : the environment (drives instruction words and dones)
// Ports       : instr_valid/instr/instr_ready    instruction handshake
//               opCode/Ri/Rj                     latched instruction fields
//               *_start / *_done                 LOAD, MOV, ALU, ALUI units
//               retire/illegal/err_timeout       one-cycle outcome pulses
//               halted/busy/retired_count        status
// Revision    : 1.0  initial release
// ============================================================================
interface instr_dispatch_if #(
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic [15:0]      instr;
  logic             instr_ready;
  logic [3:0]       opCode;
  logic [5:0]       Ri;
  logic [5:0]       Rj;
  logic             ld_start;
  logic             mov_start;
  logic             alu_start;
  logic             alui_start;
  logic             ld_done;
  logic             mov_done;
  logic             alu_done;
  logic             alui_done;
  logic             retire;
  logic             illegal;
  logic             err_timeout;
  logic             halted;
  logic             busy;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  instr_valid, instr,
    input  ld_done, mov_done, alu_done, alui_done,
    output instr_ready, opCode, Ri, Rj,
    output ld_start, mov_start, alu_start, alui_start,
    output retire, illegal, err_timeout, halted, busy, retired_count
  );

  modport slave (
    output instr_valid, instr,
    output ld_done, mov_done, alu_done, alui_done,
    input  instr_ready, opCode, Ri, Rj,
    input  ld_start, mov_start, alu_start, alui_start,
    input  retire, illegal, err_timeout, halted, busy, retired_count
  );
endinterface
`default_nettype wire

// File: rtl/instr_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : instr_dispatch
// Description : Accepts one 16-bit instruction at a time, decodes the opcode,
//               pulses the start of the matching execution unit and waits for
//               its done (bounded by TIMEOUT cycles). Retires the instruction,
//               flags illegal opcodes and timeouts, and stops on HALT until
//               reset.
// Ports       : clk    system clock, rising edge
//               rst_n  asynchronous active-low reset
//               bus    instr_dispatch_if.master (handshake, fields, unit
//                      start/done, outcome pulses and status)
// Parameters  : TIMEOUT  maximum WAIT cycles before abort (>= 1)
//               CNT_W    width of the retired-instruction counter
// Revision    : 1.0  initial release
// ============================================================================
module instr_dispatch #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_dispatch_if.master   bus
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_TIMEOUT = WAIT_W'(TIMEOUT);

  localparam logic [1:0] c_UNIT_LD   = 2'd0;
  localparam logic [1:0] c_UNIT_MOV  = 2'd1;
  localparam logic [1:0] c_UNIT_ALU  = 2'd2;
  localparam logic [1:0] c_UNIT_ALUI = 2'd3;

  localparam logic [1:0] c_RES_OK      = 2'd0;
  localparam logic [1:0] c_RES_ILLEGAL = 2'd1;
  localparam logic [1:0] c_RES_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RETIRE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            r_state, w_state_next;
  logic [3:0]        r_opcode;
  logic [5:0]        r_ri;
  logic [5:0]        r_rj;
  logic [1:0]        r_unit, w_unit_next;
  logic [1:0]        r_result, w_result_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic [WAIT_W-1:0] w_wait_cnt_inc;
  logic [CNT_W-1:0]  r_count;
  logic              w_count_inc;
  logic              w_accept;
  logic              w_sel_done;

  // Opcode classification of the latched word
  logic              w_is_unit;
  logic              w_is_nop;
  logic              w_is_halt;
  logic [1:0]        w_dec_unit;

  assign w_accept       = bus.instr_valid && (r_state == S_IDLE);
  assign w_wait_cnt_inc = r_wait_cnt + WAIT_W'(1);

  always_comb begin
    w_is_unit  = 1'b0;
    w_is_nop   = 1'b0;
    w_is_halt  = 1'b0;
    w_dec_unit = c_UNIT_LD;
    case (r_opcode)
      4'h0:                   w_is_nop  = 1'b1;
      4'h1: begin             w_is_unit = 1'b1; w_dec_unit = c_UNIT_LD;   end
      4'h2: begin             w_is_unit = 1'b1; w_dec_unit = c_UNIT_MOV;  end
      4'h3, 4'h4, 4'h5, 4'h6:
            begin             w_is_unit = 1'b1; w_dec_unit = c_UNIT_ALU;  end
      4'h7: begin             w_is_unit = 1'b1; w_dec_unit = c_UNIT_ALUI; end
      4'hF:                   w_is_halt = 1'b1;
      default:                ;
    endcase
  end

  // Only the selected unit's done is looked at; the others are don't-care.
  always_comb begin
    case (r_unit)
      c_UNIT_LD:   w_sel_done = bus.ld_done;
      c_UNIT_MOV:  w_sel_done = bus.mov_done;
      c_UNIT_ALU:  w_sel_done = bus.alu_done;
      default:     w_sel_done = bus.alui_done;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_unit     <= c_UNIT_LD;
      r_result   <= c_RES_OK;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_unit     <= w_unit_next;
      r_result   <= w_result_next;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_unit_next     = r_unit;
    w_result_next   = r_result;
    w_wait_cnt_next = r_wait_cnt;
    w_count_inc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) w_state_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_unit) begin
          w_state_next = S_ISSUE;
          w_unit_next  = w_dec_unit;
        end else if (w_is_nop) begin
          w_state_next  = S_RETIRE;
          w_result_next = c_RES_OK;
          w_count_inc   = 1'b1;
        end else if (w_is_halt) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next  = S_RETIRE;
          w_result_next = c_RES_ILLEGAL;
        end
      end
      S_ISSUE: begin
        w_wait_cnt_next = '0;
        w_state_next    = S_WAIT;
      end
      S_WAIT: begin
        // done is checked before expiry so a done in the last cycle wins
        if (w_sel_done) begin
          w_state_next  = S_RETIRE;
          w_result_next = c_RES_OK;
          w_count_inc   = 1'b1;
        end else begin
          w_wait_cnt_next = w_wait_cnt_inc;
          if (w_wait_cnt_inc == c_TIMEOUT) begin
            w_state_next  = S_RETIRE;
            w_result_next = c_RES_TIMEOUT;
          end
        end
      end
      S_RETIRE: begin
        w_state_next = S_IDLE;
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Counter advances on entry to a successful RETIRE, so the new value is
  // visible in the same cycle as the retire pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_count_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Fields held from one accept to the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= '0;
      r_ri     <= '0;
      r_rj     <= '0;
    end else if (w_accept) begin
      r_opcode <= bus.instr[15:12];
      r_ri     <= bus.instr[11:6];
      r_rj     <= bus.instr[5:0];
    end
  end

  assign bus.instr_ready   = (r_state == S_IDLE);
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.halted        = (r_state == S_HALT);
  assign bus.opCode        = r_opcode;
  assign bus.Ri            = r_ri;
  assign bus.Rj            = r_rj;
  assign bus.ld_start      = (r_state == S_ISSUE) && (r_unit == c_UNIT_LD);
  assign bus.mov_start     = (r_state == S_ISSUE) && (r_unit == c_UNIT_MOV);
  assign bus.alu_start     = (r_state == S_ISSUE) && (r_unit == c_UNIT_ALU);
  assign bus.alui_start    = (r_state == S_ISSUE) && (r_unit == c_UNIT_ALUI);
  assign bus.retire        = (r_state == S_RETIRE) && (r_result == c_RES_OK);
  assign bus.illegal       = (r_state == S_RETIRE) && (r_result == c_RES_ILLEGAL);
  assign bus.err_timeout   = (r_state == S_RETIRE) && (r_result == c_RES_TIMEOUT);
  assign bus.retired_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_dispatch
// Description : Self-checking bench for instr_dispatch. Directed scenarios
//               followed by randomized instructions and done latencies, with
//               expected timing and outcome taken from an opcode-class model.
//               A second instance with CNT_W=2 exercises counter wrap.
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_dispatch;

  localparam int TO = 15;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   exp_cnt;
  int   exp2;

  instr_dispatch_if #(.CNT_W(8)) bus ();
  instr_dispatch_if #(.CNT_W(2)) bus2 ();

  instr_dispatch #(.TIMEOUT(TO), .CNT_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  instr_dispatch #(.TIMEOUT(TO), .CNT_W(2)) u_dut_w2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] starts();
    return {bus.alui_start, bus.alu_start, bus.mov_start, bus.ld_start};
  endfunction

  function automatic logic [2:0] pulses();
    return {bus.retire, bus.illegal, bus.err_timeout};
  endfunction

  task automatic drive_dones(input logic [3:0] v);
    bus.ld_done   = v[0];
    bus.mov_done  = v[1];
    bus.alu_done  = v[2];
    bus.alui_done = v[3];
  endtask

  // 0..3 = LD/MOV/ALU/ALUI unit, 4 = NOP, 5 = illegal, 6 = HALT
  function automatic int classify(input logic [3:0] op);
    if (op == 4'h0) return 4;
    if (op == 4'h1) return 0;
    if (op == 4'h2) return 1;
    if (op >= 4'h3 && op <= 4'h6) return 2;
    if (op == 4'h7) return 3;
    if (op == 4'hF) return 6;
    return 5;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  bus.instr_ready, 1);
    chk({tag, "_starts"}, starts(), 0);
    chk({tag, "_pulses"}, pulses(), 0);
    chk({tag, "_halted"}, bus.halted, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_fields"}, {bus.opCode, bus.Ri, bus.Rj}, 0);
    chk({tag, "_count"},  bus.retired_count, 0);
  endtask

  // dly: selected done raised dly cycles after the start cycle (1..TO);
  // 0 or >TO means never. spur: random noise on done inputs that must be
  // ignored (non-selected units in WAIT, any unit during ISSUE).
  task automatic run_instr(input logic [15:0] w, input int dly, input bit spur);
    int        cls;
    int        endk;
    bit        ok;
    logic [3:0] sel;
    logic [3:0] noise;
    cls = classify(w[15:12]);
    chk("accept_ready", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    tick;                                     // T+1 DECODE
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    chk("dec_busy",   bus.busy, 1);
    chk("dec_ready",  bus.instr_ready, 0);
    chk("dec_fields", {bus.opCode, bus.Ri, bus.Rj}, w);
    chk("dec_starts", starts(), 0);
    chk("dec_pulses", pulses(), 0);
    tick;                                     // T+2
    if (cls < 4) begin
      sel = 4'b0001 << cls;
      chk("issue_start",  starts(), sel);
      chk("issue_pulses", pulses(), 0);
      drive_dones(spur ? 4'($urandom) : 4'b0000);
      ok   = (dly >= 1) && (dly <= TO);
      endk = ok ? dly : TO;
      for (int k = 1; k <= endk; k++) begin
        tick;                                 // WAIT cycle T+2+k
        noise = spur ? (4'($urandom) & ~sel) : 4'b0000;
        drive_dones(noise | ((k == dly) ? sel : 4'b0000));
        chk("wait_starts", starts(), 0);
        chk("wait_pulses", pulses(), 0);
        chk("wait_fields", {bus.opCode, bus.Ri, bus.Rj}, w);
      end
      tick;                                   // RETIRE
      drive_dones(4'b0000);
      if (ok) exp_cnt = (exp_cnt + 1) % 256;
      chk(ok ? "retire_pulse" : "timeout_pulse", pulses(), ok ? 3'b100 : 3'b001);
      chk("retire_starts", starts(), 0);
      tick;
      chk("post_ready", bus.instr_ready, 1);
      chk("post_count", bus.retired_count, exp_cnt);
    end else if (cls == 4 || cls == 5) begin
      if (cls == 4) exp_cnt = (exp_cnt + 1) % 256;
      chk(cls == 4 ? "nop_pulse" : "illegal_pulse", pulses(), cls == 4 ? 3'b100 : 3'b010);
      chk("nop_ill_starts", starts(), 0);
      tick;
      chk("post_ready", bus.instr_ready, 1);
      chk("post_count", bus.retired_count, exp_cnt);
    end else begin
      for (int k = 0; k < 50; k++) begin
        bus.instr_valid = 1'($urandom);
        chk("halt_state", {bus.halted, bus.instr_ready, bus.busy}, 3'b101);
        chk("halt_starts", starts(), 0);
        chk("halt_pulses", pulses(), 0);
        tick;
      end
      bus.instr_valid = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 0;
    exp2     = 0;
    rst_n    = 1'b0;
    bus.instr_valid  = 1'b0;
    bus.instr        = 16'h0000;
    drive_dones(4'b0000);
    bus2.instr_valid = 1'b0;
    bus2.instr       = 16'h0000;
    bus2.ld_done     = 1'b0;
    bus2.mov_done    = 1'b0;
    bus2.alu_done    = 1'b0;
    bus2.alui_done   = 1'b0;

    #3;
    chk_reset_vals("rst0");
    chk("rst0_w2_count", bus2.retired_count, 0);
    tick;
    tick;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk_reset_vals("idle0");

    // ALUI, done at T+6
    run_instr(16'h7083, 4, 1'b0);
    // back-to-back LOAD then MOV, done 3 cycles after start
    run_instr(16'h1040, 3, 1'b0);
    run_instr(16'h2081, 3, 1'b0);
    // ALU hang with noise on other dones -> timeout
    run_instr(16'h3042, 0, 1'b1);
    // illegal and NOP
    run_instr(16'h9000, 0, 1'b0);
    run_instr(16'h0000, 0, 1'b0);
    // done exactly at expiry and at the first WAIT cycle
    run_instr(16'h5abc, TO, 1'b1);
    run_instr(16'h7fff, 1, 1'b1);

    // reset during WAIT of 0x7083 at T+4
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h7083;
    tick;                                     // T+1
    bus.instr_valid = 1'b0;
    tick;                                     // T+2
    chk("mid_alui_start", starts(), 4'b1000);
    tick;                                     // T+3
    tick;                                     // T+4
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk_reset_vals("mid_rst");
    tick;
    chk_reset_vals("mid_rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    run_instr(16'h1040, 2, 1'b0);

    // randomized instructions (no HALT)
    for (int i = 0; i < 40; i++) begin
      logic [15:0] w;
      w = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(w, $urandom_range(0, TO + 2), 1'($urandom));
    end

    // HALT held, then cleared by reset
    run_instr(16'hF000, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk_reset_vals("halt_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    run_instr(16'h1040, 5, 1'b1);

    // counter wrap with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      chk("w2_ready", bus2.instr_ready, 1);
      bus2.instr_valid = 1'b1;
      bus2.instr       = 16'h0000;
      tick;
      bus2.instr_valid = 1'b0;
      tick;
      exp2 = (exp2 + 1) % 4;
      chk("w2_retire", {bus2.retire, bus2.illegal, bus2.err_timeout}, 3'b100);
      tick;
      chk("w2_count", bus2.retired_count, exp2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
